// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit active-low seven-segment display.
// Snapshots one of four debug words per frame and blanks between digit slots.
module seg_scan_ctrl #(
  parameter int TICK_DIV  = 262144,
  parameter int BLANK_CYC = 1024
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic [1:0]  sel,
  input  logic        lz_en,
  input  logic        hold,
  input  logic [7:0]  digit_mask,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - BLANK_CYC - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]       state_r;
  logic [2:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      snap_r;
  logic             lz_q_r;
  logic             first_r;
  logic [7:0]       an_r;
  logic [6:0]       seg_r;
  logic             frame_done_r;

  logic [31:0]      src_sel_s;
  logic [31:0]      upper_s;
  logic [3:0]       nib_s;
  logic             dark_s;
  logic             frame_start_s;
  logic             frame_last_s;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      4'hF:    hex_to_seg = 7'b0001110;
      default: hex_to_seg = 7'b1111111;
    endcase
  endfunction

  assign frame_start_s = (state_r == ST_BLANK) && (idx_r == 3'd0) && (cnt_r == '0);
  assign frame_last_s  = (state_r == ST_SHOW) && (idx_r == 3'd7) && (cnt_r == SHOW_LAST);

  // Source mux and digit content for the slot about to be shown.
  always_comb begin
    src_sel_s = 32'd0;
    case (sel)
      2'd0:    src_sel_s = src0;
      2'd1:    src_sel_s = src1;
      2'd2:    src_sel_s = src2;
      2'd3:    src_sel_s = src3;
      default: src_sel_s = 32'd0;
    endcase
    upper_s = snap_r >> {idx_r, 2'b00};
    nib_s   = upper_s[3:0];
    // Digit 0 is exempt from zero suppression so a zero word still shows "0".
    dark_s  = digit_mask[idx_r] | (lz_q_r & (idx_r != 3'd0) & (upper_s == 32'd0));
  end

  // Slot sequencing, per-frame snapshot and registered display outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_r      <= ST_BLANK;
      idx_r        <= 3'd0;
      cnt_r        <= '0;
      snap_r       <= 32'd0;
      lz_q_r       <= 1'b0;
      first_r      <= 1'b1;
      an_r         <= 8'hFF;
      seg_r        <= 7'h7F;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_last_s;
      if (frame_start_s) begin
        first_r <= 1'b0;
        if (!hold || first_r) begin
          snap_r <= src_sel_s;
          lz_q_r <= lz_en;
        end
      end
      case (state_r)
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_r <= ST_SHOW;
            cnt_r   <= '0;
            if (dark_s) begin
              an_r  <= 8'hFF;
              seg_r <= 7'h7F;
            end else begin
              an_r  <= ~(8'd1 << idx_r);
              seg_r <= hex_to_seg(nib_s);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            state_r <= ST_BLANK;
            cnt_r   <= '0;
            idx_r   <= idx_r + 3'd1;
            an_r    <= 8'hFF;
            seg_r   <= 7'h7F;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_BLANK;
          cnt_r   <= '0;
          an_r    <= 8'hFF;
          seg_r   <= 7'h7F;
        end
      endcase
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule
